// File: rtl/fifo_rr_sched_pkg.sv
// Shared types and constants for the fifo_rr_sched egress scheduler.
// Used by both the default build and the SCHED_STATS_EN build.
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam int CNT_W     = 8;
  localparam int BURST_MAX = 15;

  function automatic int burst_cnt_w(input int burst);
    return $clog2(burst + 1);
  endfunction

  // Sized for the largest allowed burst so BURST can change without touching the counter.
  localparam int BURST_CNT_W = burst_cnt_w(BURST_MAX);

  typedef logic [BURST_CNT_W-1:0] burst_cnt_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rr_sched_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin scheduler sharing one egress FIFO between NUM_IN ingress FIFOs.
// Define SCHED_STATS_EN to add per-source saturating forward counters on fwd_cnt.
//
// state | meaning
// IDLE  | no source granted, arbitrating
// SERVE | granted source being drained, up to BURST pops
// STALL | egress almost full, grant and burst count held
// ERROR | egress overflow trapped, only reset exits
module fifo_rr_sched
  import sched_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 10,
  parameter int BURST  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          fifo_empty,
  input  logic [NUM_IN*DATA_W-1:0]   fifo_data,
  input  logic                       out_almost_full,
  input  logic                       out_full,
  output logic [NUM_IN-1:0]          pop,
  output logic                       push_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(NUM_IN)-1:0]  grant_id,
  output logic                       active,
  output logic                       error_out
`ifdef SCHED_STATS_EN
  ,
  output logic [NUM_IN*CNT_W-1:0]    fwd_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_IN);

  state_t           state, nxt_state;
  logic [IDX_W-1:0] rr_ptr, nxt_ptr, nxt_grant;
  logic [IDX_W-1:0] grant_inc, pick_ptr, pick_idx;
  burst_cnt_t       burst_cnt, nxt_burst;
  logic             pick_found, pop_ok, last_pop, grant_end, err_now, flush;
  logic [NUM_IN-1:0] req;

  logic             p1_vld;
  logic [IDX_W-1:0] p1_src;
  logic [DATA_W-1:0] src_word [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_split
    assign src_word[g] = fifo_data[g*DATA_W +: DATA_W];
  end

  assign req       = ~fifo_empty;
  assign grant_inc = (grant_id == IDX_W'(NUM_IN - 1)) ? '0 : grant_id + 1'b1;
  // On grant end the search starts past the current grant, so it is re-picked only as a last resort.
  assign pick_ptr  = (state == SERVE) ? grant_inc : rr_ptr;
  assign pop_ok    = ~fifo_empty[grant_id] & ~out_almost_full;
  assign last_pop  = pop_ok & (burst_cnt == burst_cnt_t'(BURST - 1));
  assign grant_end = fifo_empty[grant_id] | last_pop;
  assign err_now   = push_out & out_full;
  assign flush     = err_now | (state == ERROR);

  rr_pick #(
    .N     (NUM_IN),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= nxt_state;
      grant_id  <= nxt_grant;
      rr_ptr    <= nxt_ptr;
      burst_cnt <= nxt_burst;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_grant = grant_id;
    nxt_ptr   = rr_ptr;
    nxt_burst = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          nxt_state = SERVE;
          nxt_grant = pick_idx;
          nxt_burst = '0;
        end
      end
      SERVE: begin
        // Grant end is checked before back-pressure so a final pop always rotates.
        if (grant_end) begin
          nxt_ptr = grant_inc;
          if (pick_found) begin
            nxt_state = SERVE;
            nxt_grant = pick_idx;
            nxt_burst = '0;
          end else begin
            nxt_state = IDLE;
          end
        end else if (out_almost_full) begin
          nxt_state = STALL;
        end else if (pop_ok) begin
          nxt_burst = burst_cnt + 1'b1;
        end
      end
      STALL: begin
        if (!out_almost_full) nxt_state = SERVE;
      end
      ERROR: begin
        nxt_state = ERROR;
      end
    endcase
    if (err_now) nxt_state = ERROR;
  end

  always_comb begin
    pop = '0;
    if (state == SERVE && pop_ok) pop[grant_id] = 1'b1;
  end

  assign active = (state == SERVE);

  // Two-stage datapath: source index travels with the word so grant changes are safe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_vld    <= 1'b0;
      p1_src    <= '0;
      push_out  <= 1'b0;
      data_out  <= '0;
      error_out <= 1'b0;
    end else begin
      p1_vld   <= (|pop) & ~flush;
      p1_src   <= grant_id;
      push_out <= p1_vld & ~flush;
      if (p1_vld & ~flush) data_out <= src_word[p1_src];
      if (err_now) error_out <= 1'b1;
    end
  end

`ifdef SCHED_STATS_EN
  logic [IDX_W-1:0] p2_src;
  logic [CNT_W-1:0] cnt [NUM_IN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p2_src <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else begin
      if (p1_vld & ~flush) p2_src <= p1_src;
      if (push_out) cnt[p2_src] <= sat_inc(cnt[p2_src]);
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_fwd
    assign fwd_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Self-checking bench for fifo_rr_sched: queue-based ingress FIFO models, a pop/push
// scoreboard with fixed two-cycle latency, and directed plus random scenarios.
module tb_fifo_rr_sched;

  localparam int NUM_IN = 4;
  localparam int DATA_W = 10;
  localparam int BURST  = 4;
  localparam int IDX_W  = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_IN-1:0]        fifo_empty;
  logic [NUM_IN*DATA_W-1:0] fifo_data;
  logic                     out_almost_full;
  logic                     out_full;
  logic [NUM_IN-1:0]        pop;
  logic                     push_out;
  logic [DATA_W-1:0]        data_out;
  logic [IDX_W-1:0]         grant_id;
  logic                     active;
  logic                     error_out;
`ifdef SCHED_STATS_EN
  logic [NUM_IN*8-1:0]      fwd_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rr_sched #(
    .NUM_IN (NUM_IN),
    .DATA_W (DATA_W),
    .BURST  (BURST)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .out_almost_full (out_almost_full),
    .out_full        (out_full),
    .pop             (pop),
    .push_out        (push_out),
    .data_out        (data_out),
    .grant_id        (grant_id),
    .active          (active),
    .error_out       (error_out)
`ifdef SCHED_STATS_EN
    ,
    .fwd_cnt         (fwd_cnt)
`endif
  );

  logic [DATA_W-1:0] src_q [NUM_IN][$];
  logic [DATA_W-1:0] infl_w[$];
  int                infl_due[$];
  int                pop_log[$];
  int                pop_cyc[$];
  int                cyc, total, bad;
  bit                sb_on;
  logic [NUM_IN-1:0] pend;
  logic [NUM_IN-1:0] s_pop;
  logic              s_push, s_active, s_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_IN; i++) fifo_empty[i] = (src_q[i].size() == 0);
  endtask

  task automatic load(input int src, input int n);
    for (int k = 0; k < n; k++) src_q[src].push_back(DATA_W'($urandom_range(0, 1023)));
    refresh();
  endtask

  function automatic bit drained();
    bit d = (infl_w.size() == 0);
    for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  // One clock: check at the falling edge, then update the FIFO models just after the rising edge.
  task automatic cycle_step();
    @(negedge clk);
    cyc++;
    s_pop = pop; s_push = push_out; s_active = active; s_err = error_out;
    chk("pop_onehot0", 32'($onehot0(pop)), 32'd1);
    if (pop != '0) begin
      chk("pop_is_grant", 32'(pop), 32'd1 << grant_id);
      chk("pop_src_nonempty", 32'(src_q[grant_id].size() != 0), 32'd1);
      chk("pop_no_af", 32'(out_almost_full), 32'd0);
      for (int i = 0; i < NUM_IN; i++)
        if (pop[i] && src_q[i].size() != 0) begin
          pop_log.push_back(i);
          pop_cyc.push_back(cyc);
          infl_w.push_back(src_q[i][0]);
          infl_due.push_back(cyc + 2);
        end
    end
    if (sb_on) begin
      if (infl_due.size() != 0 && infl_due[0] == cyc) begin
        chk("push_strobe", 32'(push_out), 32'd1);
        chk("push_data", 32'(data_out), 32'(infl_w[0]));
        void'(infl_w.pop_front());
        void'(infl_due.pop_front());
      end else begin
        chk("push_idle", 32'(push_out), 32'd0);
      end
    end
    pend = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_IN; i++)
      if (pend[i] && src_q[i].size() != 0) fifo_data[i*DATA_W +: DATA_W] = src_q[i].pop_front();
    refresh();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle_step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    infl_w.delete(); infl_due.delete(); pop_log.delete(); pop_cyc.delete();
    out_almost_full = 1'b0;
    out_full = 1'b0;
    sb_on = 1'b1;
    refresh();
    @(negedge clk);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_push", 32'(push_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_error", 32'(error_out), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input int exp[$]);
    chk({tag, "_count"}, 32'(pop_log.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < pop_log.size(); k++)
      chk({tag, "_src"}, 32'(pop_log[k]), 32'(exp[k]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int exp_seq[$];
    int guard;

    cyc = 0; total = 0; bad = 0;
    fifo_data = '0;
    pend = '0;

    // Single source: eight pops back to back, re-granted to the sole requester.
    do_reset();
    load(0, 8);
    c0 = cyc;
    run(14);
    exp_seq = {0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("single", exp_seq);
    for (int k = 0; k < pop_cyc.size(); k++) chk("single_pop_cycle", 32'(pop_cyc[k]), 32'(c0 + 2 + k));
    chk("single_drained", 32'(drained()), 32'd1);

    // All four sources busy: strict rotation in bursts of BURST.
    do_reset();
    for (int i = 0; i < NUM_IN; i++) load(i, 8);
    run(40);
    exp_seq.delete();
    for (int k = 0; k < 32; k++) exp_seq.push_back((k / BURST) % NUM_IN);
    chk_seq("rotate", exp_seq);
    for (int k = 1; k < pop_cyc.size(); k++) chk("rotate_no_gap", 32'(pop_cyc[k] - pop_cyc[k-1]), 32'd1);

    // Asynchronous reset in the middle of a burst drops strobes without a clock edge.
    do_reset();
    for (int i = 0; i < NUM_IN; i++) load(i, 8);
    run(6);
    @(negedge clk);
    chk("mid_busy_pop", 32'(pop != '0), 32'd1);
    chk("mid_busy_push", 32'(push_out), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pop", 32'(pop), 32'd0);
    chk("mid_rst_push", 32'(push_out), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    @(posedge clk);
    #1;

    // Back-pressure after two pops: stall holds the burst count.
    do_reset();
    load(0, 8);
    load(1, 4);
    guard = 0;
    while (pop_log.size() < 2 && guard < 20) begin cycle_step(); guard++; end
    chk("bp_reached_two", 32'(pop_log.size()), 32'd2);
    out_almost_full = 1'b1;
    cycle_step();
    chk("bp_first_pop", 32'(s_pop), 32'd0);
    chk("bp_first_active", 32'(s_active), 32'd1);
    cycle_step();
    chk("bp_stall_active", 32'(s_active), 32'd0);
    run(3);
    chk("bp_held_pops", 32'(pop_log.size()), 32'd2);
    out_almost_full = 1'b0;
    run(20);
    exp_seq = {0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    chk_seq("bp", exp_seq);

    // Source drains before its burst is used up.
    do_reset();
    load(1, 2);
    load(2, 4);
    run(12);
    exp_seq = {1, 1, 2, 2, 2, 2};
    chk_seq("drain", exp_seq);
    if (pop_cyc.size() >= 3) chk("drain_gap", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);

    // Overflow: push into a full egress is trapped and sticky until reset.
    do_reset();
    load(0, 8);
    guard = 0;
    s_push = 1'b0;
    while (!s_push && guard < 10) begin cycle_step(); guard++; end
    chk("ovf_push_seen", 32'(s_push), 32'd1);
    out_full = 1'b1;
    sb_on = 1'b0;
    cycle_step();
    cycle_step();
    chk("ovf_error_set", 32'(s_err), 32'd1);
    chk("ovf_push_flushed", 32'(s_push), 32'd0);
    for (int k = 0; k < 10; k++) begin
      cycle_step();
      chk("ovf_pop_quiet", 32'(s_pop), 32'd0);
      chk("ovf_push_quiet", 32'(s_push), 32'd0);
      chk("ovf_error_sticky", 32'(s_err), 32'd1);
    end
    do_reset();
    cycle_step();
    chk("ovf_cleared", 32'(s_err), 32'd0);
    chk("ovf_idle", 32'(s_active), 32'd0);

    // Random traffic with random back-pressure, then drain.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, NUM_IN - 1)), int'($urandom_range(1, 6)));
      out_almost_full = ($urandom_range(0, 4) == 0);
      cycle_step();
    end
    out_almost_full = 1'b0;
    guard = 0;
    while (!drained() && guard < 400) begin cycle_step(); guard++; end
    run(3);
    chk("rand_drained", 32'(drained()), 32'd1);

`ifdef SCHED_STATS_EN
    do_reset();
    load(0, 300);
    run(320);
    chk("stats_src0_sat", 32'(fwd_cnt[7:0]), 32'd255);
    chk("stats_others", 32'(fwd_cnt[31:8]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
